// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: the buffered byte entry and the
// handshake controller state encoding.
package uart_pkg;

  typedef struct packed {
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic {
    IDLE,
    ACK
  } rx_ctrl_state_t;

  localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout is always the head entry; pointers wrap at
// DEPTH (power of two) and occupancy is tracked explicitly in level.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/rx_ctrl.sv
// Receive/ReceiveAck 4-phase handshake with the UART receiver, byte buffering
// into a show-ahead FIFO, and character / parity-error / overflow status.
module rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_receive,
  input  logic [7:0]               rx_dout,
  input  logic                     rx_parity_err,
  output logic                     rx_ack,
  output logic [7:0]               dout,
  output logic                     dout_perr,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [CNT_WIDTH-1:0]     char_count,
  output logic [CNT_WIDTH-1:0]     perr_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     clr_status
);

  rx_ctrl_state_t state, state_nxt;
  rx_entry_t      wr_entry, head;
  logic           capture;
  logic           pop;
  logic           drop;
  logic           full;
  logic           empty;

  assign rx_ack     = (state == ACK);
  assign dout_valid = !empty;
  assign dout       = head.data;
  assign dout_perr  = head.perr;
  assign pop        = dout_valid && dout_ready;
  assign drop       = capture && full && !pop;

  always_comb begin
    wr_entry.perr = rx_parity_err;
    wr_entry.data = rx_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture only on the IDLE->ACK transition so a held rx_receive is taken once.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_receive) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!rx_receive) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A capture coinciding with clr_status restarts the counters from this byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_count <= '0;
      perr_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (capture) begin
        if (clr_status) begin
          char_count <= CNT_WIDTH'(1);
          perr_count <= CNT_WIDTH'(rx_parity_err);
        end else begin
          char_count <= char_count + CNT_WIDTH'(1);
          perr_count <= perr_count + CNT_WIDTH'(rx_parity_err);
        end
      end else if (clr_status) begin
        char_count <= '0;
        perr_count <= '0;
      end
      if (drop)            overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed bench for rx_ctrl: a scoreboard queue of expected FIFO entries plus
// a small model of the counters and overflow flag.
module tb_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_receive;
  logic [7:0]    rx_dout;
  logic          rx_parity_err;
  logic          rx_ack;
  logic [7:0]    dout;
  logic          dout_perr;
  logic          dout_valid;
  logic          dout_ready;
  logic [CW-1:0] char_count;
  logic [CW-1:0] perr_count;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          clr_status;

  rx_entry_t     sb[$];
  logic [CW-1:0] m_char;
  logic [CW-1:0] m_perr;
  logic          m_ovf;
  int            n_assert = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  rx_ctrl #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_receive    (rx_receive),
    .rx_dout       (rx_dout),
    .rx_parity_err (rx_parity_err),
    .rx_ack        (rx_ack),
    .dout          (dout),
    .dout_perr     (dout_perr),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .char_count    (char_count),
    .perr_count    (perr_count),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .clr_status    (clr_status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_level"}, 32'(fifo_level), 32'(sb.size()));
    chk({tag, "_valid"}, 32'(dout_valid), 32'(sb.size() > 0));
    chk({tag, "_char"},  32'(char_count), 32'(m_char));
    chk({tag, "_perr"},  32'(perr_count), 32'(m_perr));
    chk({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
    if (sb.size() > 0) chk({tag, "_head"}, 32'({dout_perr, dout}), 32'(sb[0]));
  endtask

  // Called at a negedge; one full handshake, optionally with a pop and/or
  // clr_status in the capture cycle and rx_receive held for extra cycles.
  task automatic capture(input logic [7:0] d, input logic p, input logic pop_same,
                         input logic clr_same, input int hold);
    rx_entry_t e;
    logic      popped;
    e.perr = p;
    e.data = d;
    rx_receive    = 1'b1;
    rx_dout       = d;
    rx_parity_err = p;
    clr_status    = clr_same;
    popped        = 1'b0;
    if (pop_same && sb.size() > 0) begin
      chk("pop_same_head", 32'({dout_perr, dout}), 32'(sb[0]));
      void'(sb.pop_front());
      popped     = 1'b1;
      dout_ready = 1'b1;
    end
    if (clr_same) begin
      m_char = 8'd1;
      m_perr = CW'(p);
      m_ovf  = 1'b0;
    end else begin
      m_char = m_char + 8'd1;
      m_perr = m_perr + CW'(p);
    end
    if (sb.size() < DEPTH) sb.push_back(e);
    else                   m_ovf = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    clr_status = 1'b0;
    chk("ack_hi", 32'(rx_ack), 32'd1);
    chk_status(popped ? "cap_pop" : "cap");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("ack_hold", 32'(rx_ack), 32'd1);
      chk("hold_char", 32'(char_count), 32'(m_char));
    end
    rx_receive = 1'b0;
    @(negedge clk);
    chk("ack_lo", 32'(rx_ack), 32'd0);
  endtask

  task automatic pop_one(input string tag);
    rx_entry_t exp;
    chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %0h expected none", tag, {dout_perr, dout});
    end else begin
      exp = sb.pop_front();
      chk({tag, "_data"}, 32'({dout_perr, dout}), 32'(exp));
    end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    chk({tag, "_lvl"}, 32'(fifo_level), 32'(sb.size()));
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    m_char = '0;
    m_perr = '0;
    m_ovf  = 1'b0;
    @(negedge clk);
    clr_status = 1'b0;
    chk_status("clr");
  endtask

  initial begin
    rst = 1'b1;
    rx_receive = 1'b0;
    rx_dout = '0;
    rx_parity_err = 1'b0;
    dout_ready = 1'b0;
    clr_status = 1'b0;
    m_char = '0;
    m_perr = '0;
    m_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(rx_ack), 32'd0);
    chk_status("rst");
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte, rx_receive held in ACK must not be recaptured
    capture(8'h41, 1'b0, 1'b0, 1'b0, 3);
    pop_one("t1");

    // 2: parity pattern 0,1,0
    capture(8'h10, 1'b0, 1'b0, 1'b0, 0);
    capture(8'h21, 1'b1, 1'b0, 1'b0, 0);
    capture(8'h32, 1'b0, 1'b0, 1'b0, 0);
    chk("t2_perr", 32'(perr_count), 32'd1);
    for (int i = 0; i < 3; i++) pop_one("t2");

    // 3: overflow with DEPTH+2 bytes
    clear_status();
    for (int i = 0; i < DEPTH + 2; i++) capture(8'(8'h80 + i), 1'(i % 3 == 0), 1'b0, 1'b0, 0);
    chk("t3_level", 32'(fifo_level), 32'(DEPTH));
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_char", 32'(char_count), 32'(DEPTH + 2));
    for (int i = 0; i < DEPTH; i++) pop_one("t3");
    chk("t3_empty", 32'(dout_valid), 32'd0);

    // 4: full FIFO, pop and capture in the same cycle
    clear_status();
    for (int i = 0; i < DEPTH; i++) capture(8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 0);
    capture(8'h5A, 1'b1, 1'b1, 1'b0, 0);
    chk("t4_level", 32'(fifo_level), 32'(DEPTH));
    chk("t4_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_one("t4");

    // 5: counter wrap, then clr_status with data queued
    clear_status();
    for (int i = 0; i < 256; i++) begin
      capture(8'(i * 7), 1'(i % 5 == 0), 1'b0, 1'b0, 0);
      pop_one("t5w");
    end
    chk("t5_wrap", 32'(char_count), 32'd0);
    capture(8'hC3, 1'b1, 1'b0, 1'b0, 0);
    capture(8'h3C, 1'b0, 1'b0, 1'b0, 0);
    clear_status();
    capture(8'h77, 1'b1, 1'b0, 1'b1, 0);
    chk("t5_clr_cap_char", 32'(char_count), 32'd1);
    chk("t5_clr_cap_perr", 32'(perr_count), 32'd1);
    for (int i = 0; i < 3; i++) pop_one("t5");

    // 6: async reset mid-ACK with 3 bytes queued
    for (int i = 0; i < 3; i++) capture(8'(8'hE0 + i), 1'b0, 1'b0, 1'b0, 0);
    rx_receive = 1'b1;
    rx_dout    = 8'hEE;
    @(posedge clk);
    #2;
    chk("t6_ack_pre", 32'(rx_ack), 32'd1);
    rst = 1'b1;
    #1;
    sb.delete();
    m_char = '0;
    m_perr = '0;
    m_ovf  = 1'b0;
    chk("t6_ack", 32'(rx_ack), 32'd0);
    chk_status("t6");
    rx_receive = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_status("t6_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
